blk_grid_seq: RTL

- Sequencer for the block-luma accumulator. Consumes raw input video timing (vs/hs/de) and drives all bank control.
- Drives accumulate-enable and block index, band swap, bank clear, and per-frame format status.
- Sits between the input sync registers and the two-bank block buffer. Replaces ad-hoc counters with one checked FSM.

---
 rtl/vid_pkg.sv | 22 ++
 rtl/edge_det.sv | 23 ++
 rtl/blk_grid_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vid_pkg.sv
// Shared video-timing types, default geometry and helpers for the block-luma path.
package vid_pkg;

  typedef enum logic [1:0] {
    S_WAIT_VS,
    S_VS,
    S_BLANK,
    S_LINE
  } state_e;

  localparam int unsigned WN_DEF = 1920;
  localparam int unsigned KH_DEF = 20;
  localparam int unsigned KV_DEF = 10;
  // Left/right active-area margins; zero for the current sensor.
  localparam int unsigned ML_DEF = 0;
  localparam int unsigned MR_DEF = 0;

  function automatic int unsigned blocks_per_line(int unsigned wn, int unsigned kh);
    return wn / kh;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Single-bit rise/fall pulse generator built from a registered copy of the input.
module edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/blk_grid_seq.sv
// Block-grid sequencer: turns raw vs/hs/de timing into accumulate, swap and clear controls.
// Optional per-frame line/pixel statistics are enabled with BLK_GRID_SEQ_STATS_EN.
module blk_grid_seq
  import vid_pkg::*;
#(
  parameter int unsigned WN = WN_DEF,
  parameter int unsigned KH = KH_DEF,
  parameter int unsigned KV = KV_DEF,
  localparam int unsigned NB = blocks_per_line(WN, KH),
  localparam int unsigned IW = $clog2(NB),
  localparam int unsigned VW = $clog2(KV)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          vs_i,
  input  logic          hs_i,
  input  logic          de_i,
  output logic          acc_en_o,
  output logic [IW-1:0] acc_idx_o,
  output logic          swap_o,
  output logic          clr_o,
  output logic          frame_o,
  output logic [VW-1:0] vp_o,
  output logic          err_o,
  output logic          locked_o
`ifdef BLK_GRID_SEQ_STATS_EN
  ,
  output logic [15:0]   lines_o,
  output logic [31:0]   pix_o
`endif
);

  localparam int unsigned HW = $clog2(KH);
  // Wide enough to see a line that runs past WN without wrapping.
  localparam int unsigned PW = $clog2(WN + 1) + 1;

  logic vs_rise, vs_fall, hs_rise, de_fall;
  logic unused_hs_fall, unused_de_rise, unused_vs_fall;

  edge_det u_vs_edge (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(vs_i), .rise_o(vs_rise),
                      .fall_o(vs_fall));
  edge_det u_hs_edge (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(hs_i), .rise_o(hs_rise),
                      .fall_o(unused_hs_fall));
  edge_det u_de_edge (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(de_i), .rise_o(unused_de_rise),
                      .fall_o(de_fall));

  assign unused_vs_fall = vs_fall;

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [IW-1:0] hb_q, hb_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [VW-1:0] vp_q, vp_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;
  logic          acc_en_q, acc_en_d;
  logic [IW-1:0] acc_idx_q, acc_idx_d;
  logic          swap_q, swap_d;
  logic          clr_q, clr_d;
  logic          frame_q, frame_d;

  logic in_frame, pix, line_end;

  assign in_frame = (state_q == S_BLANK) || (state_q == S_LINE);
  // vs has priority over both pixel and line-end handling in the same cycle.
  assign pix      = in_frame && de_i && !vs_i;
  assign line_end = (state_q == S_LINE) && de_fall && !vs_i;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    hb_d      = hb_q;
    ovf_d     = ovf_q;
    pcnt_d    = pcnt_q;
    vp_d      = vp_q;
    err_d     = err_q;
    locked_d  = locked_q;
    acc_en_d  = 1'b0;
    acc_idx_d = acc_idx_q;
    swap_d    = 1'b0;
    clr_d     = 1'b0;
    frame_d   = 1'b0;

    if (hs_rise && de_i && in_frame) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      S_WAIT_VS: begin
        if (vs_i) state_d = S_VS;
      end
      S_VS: begin
        if (!vs_i) begin
          state_d = S_BLANK;
          frame_d = 1'b1;
          h_d     = '0;
          hb_d    = '0;
          ovf_d   = 1'b0;
          pcnt_d  = '0;
          vp_d    = '0;
          err_d   = 1'b0;
        end
      end
      S_BLANK: begin
        if (vs_i) begin
          state_d = S_VS;
        end else if (de_i) begin
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        if (vs_i) begin
          state_d = S_VS;
        end else if (!de_i) begin
          state_d = S_BLANK;
        end
      end
      default: state_d = S_WAIT_VS;
    endcase

    if (pix) begin
      acc_idx_d = hb_q;
      if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
      // ovf_q marks that the last block of the line has been filled.
      if (ovf_q) begin
        err_d = 1'b1;
      end else begin
        acc_en_d = 1'b1;
        if (h_q == HW'(KH - 1)) begin
          h_d = '0;
          if (hb_q == IW'(NB - 1)) begin
            ovf_d = 1'b1;
          end else begin
            hb_d = hb_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
    end

    if (line_end) begin
      if (pcnt_q != PW'(WN)) err_d = 1'b1;
      h_d    = '0;
      hb_d   = '0;
      ovf_d  = 1'b0;
      pcnt_d = '0;
      if (vp_q == VW'(KV - 1)) begin
        vp_d   = '0;
        swap_d = 1'b1;
      end else begin
        vp_d = vp_q + 1'b1;
      end
    end

    if (vs_rise) begin
      if ((vp_q != '0) || (state_q == S_LINE)) clr_d = 1'b1;
      if (state_q == S_LINE) err_d = 1'b1;
      if (state_q == S_BLANK) locked_d = ~err_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_WAIT_VS;
      h_q       <= '0;
      hb_q      <= '0;
      ovf_q     <= 1'b0;
      pcnt_q    <= '0;
      vp_q      <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_idx_q <= '0;
      swap_q    <= 1'b0;
      clr_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      hb_q      <= hb_d;
      ovf_q     <= ovf_d;
      pcnt_q    <= pcnt_d;
      vp_q      <= vp_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      acc_en_q  <= acc_en_d;
      acc_idx_q <= acc_idx_d;
      swap_q    <= swap_d;
      clr_q     <= clr_d;
      frame_q   <= frame_d;
    end
  end

  assign acc_en_o  = acc_en_q;
  assign acc_idx_o = acc_idx_q;
  assign swap_o    = swap_q;
  assign clr_o     = clr_q;
  assign frame_o   = frame_q;
  assign vp_o      = vp_q;
  assign err_o     = err_q;
  assign locked_o  = locked_q;

`ifdef BLK_GRID_SEQ_STATS_EN
  logic [15:0] lines_cnt_q, lines_q;
  logic [31:0] pix_cnt_q, pix_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lines_cnt_q <= '0;
      pix_cnt_q   <= '0;
      lines_q     <= '0;
      pix_q       <= '0;
    end else if (vs_rise) begin
      lines_q     <= lines_cnt_q;
      pix_q       <= pix_cnt_q;
      lines_cnt_q <= '0;
      pix_cnt_q   <= '0;
    end else begin
      if (line_end && (lines_cnt_q != '1)) lines_cnt_q <= lines_cnt_q + 1'b1;
      if (pix && (pix_cnt_q != '1)) pix_cnt_q <= pix_cnt_q + 1'b1;
    end
  end

  assign lines_o = lines_q;
  assign pix_o   = pix_q;
`endif

endmodule
